temperature_controller: RTL and testbench

//  Consumes the low/high abnormality flags produced by the temperature

---
 rtl/temperature_controller.sv | 107 ++++++++++
 tb/tb_temperature_controller.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/temperature_controller.sv
// Heater/cooler supervisor: debounces the analyzer's low/high abnormality flags,
// enforces a minimum actuator on-time and latches a fault on runaway actuation.
module temperature_controller #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MIN_ON_CYCLES   = 8,
  parameter int ALARM_CYCLES    = 64,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lowTempAbnormality,
  input  logic       highTempAbnormality,
  input  logic       clearFault,
  output logic       heaterOn,
  output logic       coolerOn,
  output logic       alarm,
  output logic [1:0] ctrlState
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    HEATING = 2'b01,
    COOLING = 2'b10,
    FAULT   = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] DEB_MAX   = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] MINON_MAX = CNT_W'(MIN_ON_CYCLES);
  localparam logic [CNT_W-1:0] ALARM_LIM = CNT_W'(ALARM_CYCLES);

  state_t           state, nextState;
  logic [CNT_W-1:0] lowCnt, highCnt, onCnt, abnCnt;
  logic [CNT_W-1:0] lowCntNext, highCntNext, onCntNext, abnCntNext;
  logic [CNT_W-1:0] abnInc;
  logic             lowQual, highQual, lowStable, highStable, activeFlag;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] lim);
    return (v >= lim) ? lim : v + CNT_W'(1);
  endfunction

  // Both flags asserted together is illegal and qualifies as neither.
  assign lowQual    = lowTempAbnormality & ~highTempAbnormality;
  assign highQual   = highTempAbnormality & ~lowTempAbnormality;
  assign lowStable  = lowQual && (lowCnt >= DEB_LAST);
  assign highStable = highQual && (highCnt >= DEB_LAST);

  always_comb begin
    nextState   = state;
    lowCntNext  = '0;
    highCntNext = '0;
    onCntNext   = '0;
    abnCntNext  = '0;
    activeFlag  = (state == HEATING) ? lowTempAbnormality : highTempAbnormality;
    abnInc      = abnCnt + CNT_W'(1);
    // Debounce only runs in IDLE, so any flag seen while actuating restarts here.
    case (state)
      IDLE: begin
        if (lowStable) begin
          nextState = HEATING;
        end else if (highStable) begin
          nextState = COOLING;
        end else begin
          lowCntNext  = lowQual  ? satInc(lowCnt,  DEB_MAX) : '0;
          highCntNext = highQual ? satInc(highCnt, DEB_MAX) : '0;
        end
      end
      HEATING, COOLING: begin
        if (activeFlag && (abnInc == ALARM_LIM)) begin
          nextState = FAULT;
        end else if (!activeFlag && (onCnt == MINON_MAX)) begin
          nextState = IDLE;
        end else begin
          onCntNext  = satInc(onCnt, MINON_MAX);
          abnCntNext = activeFlag ? abnInc : '0;
        end
      end
      FAULT: begin
        if (clearFault) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      lowCnt  <= '0;
      highCnt <= '0;
      onCnt   <= '0;
      abnCnt  <= '0;
    end else begin
      state   <= nextState;
      lowCnt  <= lowCntNext;
      highCnt <= highCntNext;
      onCnt   <= onCntNext;
      abnCnt  <= abnCntNext;
    end
  end

  assign heaterOn  = (state == HEATING);
  assign coolerOn  = (state == COOLING);
  assign alarm     = (state == FAULT);
  assign ctrlState = state;

endmodule

// File: tb/tb_temperature_controller.sv
// Directed-vector bench for temperature_controller at default parameters,
// followed by a random flag stress run with an actuator-exclusion check.
module tb_temperature_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       low = 1'b0;
  logic       high = 1'b0;
  logic       clearFault = 1'b0;
  logic       heaterOn, coolerOn, alarm;
  logic [1:0] ctrlState;

  int vecCount = 0;
  int errCount = 0;

  temperature_controller dut (
    .clk                 (clk),
    .rst                 (rst),
    .lowTempAbnormality  (low),
    .highTempAbnormality (high),
    .clearFault          (clearFault),
    .heaterOn            (heaterOn),
    .coolerOn            (coolerOn),
    .alarm               (alarm),
    .ctrlState           (ctrlState)
  );

  always #5 clk = ~clk;

  assert property (@(posedge clk) disable iff (rst) !(heaterOn && coolerOn));

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vecCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic flags(input logic l, input logic h);
    low  = l;
    high = h;
  endtask

  task automatic pulseClear();
    clearFault = 1'b1;
    tick(1);
    clearFault = 1'b0;
  endtask

  initial begin
    // Reset state
    #1 rst = 1'b1;
    #3;
    chk("rst_state", 8'(ctrlState), 8'h0);
    chk("rst_heater", 8'(heaterOn), 8'h0);
    chk("rst_cooler", 8'(coolerOn), 8'h0);
    chk("rst_alarm", 8'(alarm), 8'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Short low pulse must not engage, and its count must be discarded
    flags(1, 0); tick(3);
    chk("low3_heater", 8'(heaterOn), 8'h0);
    flags(0, 0); tick(1);
    flags(1, 0); tick(3);
    chk("low3_again_state", 8'(ctrlState), 8'h0);
    tick(1);
    chk("low4_heater", 8'(heaterOn), 8'h1);
    chk("low4_state", 8'(ctrlState), 8'h1);

    // Minimum on-time: entry edge, two more low edges, then low drops
    tick(2);
    flags(0, 0); tick(6);
    chk("minon_heater_held", 8'(heaterOn), 8'h1);
    chk("minon_cooler", 8'(coolerOn), 8'h0);
    tick(1);
    chk("minon_exit_state", 8'(ctrlState), 8'h0);
    chk("minon_exit_heater", 8'(heaterOn), 8'h0);

    // Async reset in the middle of HEATING
    flags(1, 0); tick(4);
    chk("pre_rst_heater", 8'(heaterOn), 8'h1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_heater", 8'(heaterOn), 8'h0);
    chk("midrst_state", 8'(ctrlState), 8'h0);
    rst = 1'b0;
    tick(3);
    chk("recover3_state", 8'(ctrlState), 8'h0);
    tick(1);
    chk("recover4_state", 8'(ctrlState), 8'h1);
    flags(0, 0); tick(9);
    chk("recover_exit", 8'(ctrlState), 8'h0);

    // Cooling runaway -> fault at exactly ALARM_CYCLES
    flags(0, 1); tick(4);
    chk("cool_on", 8'(coolerOn), 8'h1);
    tick(63);
    chk("cool63_state", 8'(ctrlState), 8'h2);
    tick(1);
    chk("cool64_state", 8'(ctrlState), 8'h3);
    chk("cool64_cooler", 8'(coolerOn), 8'h0);
    chk("cool64_alarm", 8'(alarm), 8'h1);
    flags(0, 0); tick(5);
    chk("fault_sticky", 8'(alarm), 8'h1);
    flags(1, 0); tick(5);
    chk("fault_ignore_state", 8'(ctrlState), 8'h3);
    chk("fault_ignore_heater", 8'(heaterOn), 8'h0);
    pulseClear();
    chk("clear_state", 8'(ctrlState), 8'h0);
    chk("clear_alarm", 8'(alarm), 8'h0);
    tick(3);
    chk("clear_deb3", 8'(ctrlState), 8'h0);
    tick(1);
    chk("clear_deb4", 8'(ctrlState), 8'h1);

    // clearFault has no effect in HEATING or IDLE
    pulseClear();
    chk("clr_in_heat", 8'(ctrlState), 8'h1);
    flags(0, 0); tick(7);
    chk("clr_heat_held", 8'(ctrlState), 8'h1);
    tick(1);
    chk("clr_heat_exit", 8'(ctrlState), 8'h0);
    pulseClear();
    chk("clr_in_idle", 8'(ctrlState), 8'h0);

    // Heating runaway -> fault
    flags(1, 0); tick(4);
    tick(63);
    chk("heat63_state", 8'(ctrlState), 8'h1);
    tick(1);
    chk("heat64_state", 8'(ctrlState), 8'h3);
    chk("heat64_heater", 8'(heaterOn), 8'h0);
    flags(0, 0);
    pulseClear();
    chk("heat_clear", 8'(ctrlState), 8'h0);

    // Both flags together are illegal and never debounce
    flags(1, 1); tick(10);
    chk("both_state", 8'(ctrlState), 8'h0);
    flags(0, 1); tick(3);
    chk("both_after3", 8'(ctrlState), 8'h0);
    tick(1);
    chk("both_after4", 8'(ctrlState), 8'h2);
    flags(0, 0); tick(8);
    chk("cool_held", 8'(ctrlState), 8'h2);
    tick(1);
    chk("cool_exit", 8'(ctrlState), 8'h0);

    // high during HEATING: no direct switch, debounce restarts in IDLE
    flags(1, 0); tick(4);
    chk("h2c_heat", 8'(ctrlState), 8'h1);
    flags(0, 1);
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk("h2c_no_cooler", 8'(coolerOn), 8'h0);
    end
    tick(1);
    chk("h2c_idle", 8'(ctrlState), 8'h0);
    tick(3);
    chk("h2c_deb3", 8'(coolerOn), 8'h0);
    tick(1);
    chk("h2c_deb4", 8'(coolerOn), 8'h1);
    flags(0, 0); tick(9);
    chk("h2c_exit", 8'(ctrlState), 8'h0);

    // Random flag stress
    for (int i = 0; i < 10000; i++) begin
      low        = 1'($urandom_range(0, 1));
      high       = 1'($urandom_range(0, 1));
      clearFault = ($urandom_range(0, 15) == 0);
      tick(1);
      chk("excl", 8'(heaterOn & coolerOn), 8'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
